pdu_multi: RTL

Parametrised successor of the board-level processor debug unit. It sits between the board I/O (switches, buttons, LEDs, 7-segment display) and the pipelined CPU, and has three jobs:
- Generate the CPU clock: free-run, or multi-cycle step bursts.
- Serve the memory-mapped I/O bus.
- Let the user browse results, the register file, data memory and an arbitrary number of pipeline-register words.

---
 rtl/pdu_multi.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pdu_multi.sv
`default_nettype none
// ============================================================================
// Module   : pdu_multi
// Purpose  : Processor debug unit. Generates the CPU clock (free-run or
//            multi-cycle step bursts), serves the memory-mapped I/O bus and
//            lets the user browse results, regfile, data memory and
//            pipeline-register words on LEDs and a 7-segment display.
// Options  : PDU_MULTI_BRK_EN - PC breakpoint register (I/O 0x18) and halt
//            flag (bit 1 of I/O 0x1C).
// Revision : 1.0 - initial release
// ============================================================================
module pdu_multi #(
  parameter int IN_W      = 5,
  parameter int N_DIGITS  = 8,
  parameter int SCAN_BITS = 20,
  parameter int N_PLR     = 16,
  parameter int LEN_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        run,
  input  logic                        step,
  input  logic                        valid,
  input  logic [IN_W-1:0]             in,
  output logic                        clk_cpu,
  output logic [1:0]                  check,
  output logic [IN_W-1:0]             out0,
  output logic [$clog2(N_DIGITS)-1:0] an,
  output logic [3:0]                  seg,
  output logic                        ready,
  input  logic [7:0]                  io_addr,
  input  logic [31:0]                 io_dout,
  input  logic                        io_we,
  output logic [31:0]                 io_din,
  output logic [7:0]                  m_rf_addr,
  input  logic [31:0]                 rf_data,
  input  logic [31:0]                 m_data,
  input  logic [32*N_PLR-1:0]         plr_bus
);

  localparam int c_AN_W  = $clog2(N_DIGITS);
  localparam int c_PLR_W = (N_PLR > 1) ? $clog2(N_PLR) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } step_state_t;

  // Synchroniser stages and edge-detect history
  logic            r_run_s, r_run_r;
  logic            r_step_s, r_step_r, r_step_d;
  logic            r_valid_s, r_valid_r, r_valid_d;
  logic [IN_W-1:0] r_in_s, r_in_r;
  logic [1:0]      r_pn_d;

  step_state_t      r_state;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] r_step_len;
  logic [IN_W-1:0]  r_out0;
  logic [31:0]      r_out1;
  logic [4:0]       r_idx;
  logic [c_PLR_W-1:0] r_plr_idx;
  logic [SCAN_BITS-1:0] r_scan;

  logic        w_step_p, w_valid_e, w_next_e, w_prev_e, w_busy;
  logic        w_hold, w_halted;
  logic [31:0] w_brk_rd;
  logic [31:0] w_plr_words [N_PLR];
  logic [31:0] w_plr_sel;
  logic [31:0] w_disp;

  for (genvar k = 0; k < N_PLR; k++) begin : g_plr
    assign w_plr_words[k] = plr_bus[32*k +: 32];
  end

  // Two-flop synchronisers plus one history stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_s   <= 1'b0; r_run_r   <= 1'b0;
      r_step_s  <= 1'b0; r_step_r  <= 1'b0; r_step_d  <= 1'b0;
      r_valid_s <= 1'b0; r_valid_r <= 1'b0; r_valid_d <= 1'b0;
      r_in_s    <= '0;   r_in_r    <= '0;   r_pn_d    <= 2'b00;
    end else begin
      r_run_s   <= run;   r_run_r   <= r_run_s;
      r_step_s  <= step;  r_step_r  <= r_step_s;  r_step_d  <= r_step_r;
      r_valid_s <= valid; r_valid_r <= r_valid_s; r_valid_d <= r_valid_r;
      r_in_s    <= in;    r_in_r    <= r_in_s;    r_pn_d    <= r_in_r[1:0];
    end
  end

  assign w_step_p  = r_step_r & ~r_step_d;
  assign w_valid_e = r_valid_r ^ r_valid_d;
  assign w_next_e  = r_in_r[0] ^ r_pn_d[0];
  assign w_prev_e  = r_in_r[1] ^ r_pn_d[1];
  assign w_busy    = (r_state != S_IDLE);

`ifdef PDU_MULTI_BRK_EN
  logic [31:0] r_brk;
  logic        r_halted;
  logic        r_run_d;

  // Breakpoint register; halt on PC match while free-running, release on run falling edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_brk    <= 32'hFFFF_FFFF;
      r_halted <= 1'b0;
      r_run_d  <= 1'b0;
    end else begin
      r_run_d <= r_run_r;
      if (io_we && io_addr == 8'h18) r_brk <= io_dout;
      if (r_run_d && !r_run_r)
        r_halted <= 1'b0;
      else if (r_run_r && !clk_cpu && w_plr_words[0] == r_brk)
        r_halted <= 1'b1;
    end
  end

  assign w_hold   = r_halted | (~clk_cpu & (w_plr_words[0] == r_brk));
  assign w_halted = r_halted;
  assign w_brk_rd = r_brk;
`else
  assign w_hold   = 1'b0;
  assign w_halted = 1'b0;
  assign w_brk_rd = 32'h0;
`endif

  // CPU clock: free-run toggle, or step-burst FSM emitting one-clk-high pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cpu     <= 1'b0;
      r_state     <= S_IDLE;
      r_remaining <= '0;
    end else if (r_run_r) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      clk_cpu     <= w_hold ? 1'b0 : ~clk_cpu;
    end else begin
      case (r_state)
        S_IDLE: begin
          clk_cpu <= 1'b0;
          if (w_step_p) begin
            r_remaining <= (r_step_len == '0) ? LEN_W'(1) : r_step_len;
            r_state     <= S_HIGH;
          end
        end
        S_HIGH: begin
          clk_cpu <= 1'b1;
          r_state <= S_LOW;
        end
        S_LOW: begin
          clk_cpu     <= 1'b0;
          r_remaining <= r_remaining - LEN_W'(1);
          r_state     <= (r_remaining <= LEN_W'(1)) ? S_IDLE : S_HIGH;
        end
        default: begin
          clk_cpu <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Bus-writable registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out0     <= '1;
      r_out1     <= 32'h1234_5678;
      ready      <= 1'b1;
      r_step_len <= LEN_W'(1);
    end else if (io_we) begin
      case (io_addr)
        8'h00:   r_out0     <= io_dout[IN_W-1:0];
        8'h04:   ready      <= io_dout[0];
        8'h08:   r_out1     <= io_dout;
        8'h14:   r_step_len <= io_dout[LEN_W-1:0];
        default: ;
      endcase
    end
  end

  // Combinational bus read mux
  always_comb begin
    io_din = 32'h0;
    case (io_addr)
      8'h0C:   io_din = 32'(r_in_r);
      8'h10:   io_din = {31'h0, r_valid_r};
      8'h14:   io_din = 32'(r_step_len);
      8'h18:   io_din = w_brk_rd;
      8'h1C:   io_din = {30'h0, w_halted, w_busy};
      default: io_din = 32'h0;
    endcase
  end

  // View selection: run or step forces the result view, valid edges walk down
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       check <= 2'b00;
    else if (r_run_r || w_step_p)  check <= 2'b00;
    else if (w_valid_e)            check <= check - 2'b01;
  end

  // Browse indices; simultaneous prev and next cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_plr_idx <= '0;
    end else if (w_step_p) begin
      r_idx     <= '0;
      r_plr_idx <= '0;
    end else if (w_next_e && !w_prev_e) begin
      r_idx     <= r_idx + 5'd1;
      r_plr_idx <= (r_plr_idx == c_PLR_W'(N_PLR-1)) ? '0 : r_plr_idx + c_PLR_W'(1);
    end else if (w_prev_e && !w_next_e) begin
      r_idx     <= r_idx - 5'd1;
      r_plr_idx <= (r_plr_idx == '0) ? c_PLR_W'(N_PLR-1) : r_plr_idx - c_PLR_W'(1);
    end
  end

  // Display refresh counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_scan <= '0;
    else     r_scan <= r_scan + SCAN_BITS'(1);
  end

  assign w_plr_sel = w_plr_words[r_plr_idx];
  assign m_rf_addr = (check == 2'b10) ? {r_in_r[4:2], r_idx} : {3'b000, r_idx};

  // LED and 7-segment word selection by current view
  always_comb begin
    out0   = r_out0;
    w_disp = r_out1;
    case (check)
      2'b01:   begin out0 = IN_W'(r_idx);     w_disp = rf_data;   end
      2'b10:   begin out0 = IN_W'(r_idx);     w_disp = m_data;    end
      2'b11:   begin out0 = IN_W'(r_plr_idx); w_disp = w_plr_sel; end
      default: begin out0 = r_out0;           w_disp = r_out1;    end
    endcase
  end

  assign an  = r_scan[SCAN_BITS-1 -: c_AN_W];
  assign seg = w_disp[{an, 2'b00} +: 4];

endmodule
`default_nettype wire
